// File: rtl/div_ctrl_pkg.sv
// Shared types and constants for the EX-stage divider sequencing controller.
package div_ctrl_pkg;

  localparam int DIV_LATENCY_DEF = 8;
  localparam int WD_SLACK_DEF    = 2;
  localparam int WD_W            = $clog2(DIV_LATENCY_DEF + WD_SLACK_DEF + 1);

  // Result written to LO when the divisor is zero.
  localparam logic [31:0] DIV0_LO = 32'hFFFF_FFFF;
  // Most negative signed word; SMIN / -1 overflows.
  localparam logic [31:0] SMIN    = 32'h8000_0000;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_e;

endpackage

// File: rtl/div_watchdog.sv
// Cycle counter with synchronous clear, count enable and a terminal-count flag.
// The counter parks at its terminal value so it never wraps back to zero.
module div_watchdog #(
  parameter int W     = 4,
  parameter int LIMIT = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam logic [W-1:0] LAST = W'(LIMIT - 1);

  logic [W-1:0] cnt_q, cnt_d;

  assign tc_o = (cnt_q == LAST);

  // Next count: clear wins, otherwise advance until the terminal value.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && !tc_o) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/div_hilo_ctrl.sv
// Sequences div/divu/mthi/mtlo between EX and the shared iterative divider,
// owns HI/LO, short-circuits divide-by-zero and signed overflow, and drains
// an annulled division so the divider never resumes a stale operation.
// The divider's Annual input is tied low by the integrator: it only freezes
// the divider's counter, which this controller never wants.
module div_hilo_ctrl
  import div_ctrl_pkg::*;
#(
  parameter int DIV_LATENCY = DIV_LATENCY_DEF,
  parameter int WD_SLACK    = WD_SLACK_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_div,
  input  logic        ex_signed,
  input  logic [31:0] ex_a,
  input  logic [31:0] ex_b,
  input  logic        ex_mthi,
  input  logic        ex_mtlo,
  input  logic [31:0] ex_wdata,
  input  logic        flush,
  output logic        stall_o,
  output logic        div_start,
  output logic        div_signed,
  output logic [31:0] div_a,
  output logic [31:0] div_b,
  input  logic [63:0] div_result,
  input  logic        div_ready,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        hilo_wr,
  output logic        div_timeout
);

  localparam int WD_LIMIT = DIV_LATENCY + WD_SLACK;
  localparam int WD_BITS  = $clog2(WD_LIMIT + 1);

  state_e      state_q, state_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [31:0] a_q, a_d, b_q, b_d;
  logic        sgn_q, sgn_d;
  logic        wr_q, wr_d;
  logic        to_q, to_d;
  logic        wd_clr, wd_tc;
  logic        is_div0, is_ovf;

  assign is_div0 = (ex_b == '0);
  assign is_ovf  = ex_signed && (ex_a == SMIN) && (ex_b == '1);

  // Start must fall in the Ready cycle or the divider would relaunch.
  assign div_start = (state_q != IDLE) && !div_ready;

  div_watchdog #(
    .W     (WD_BITS),
    .LIMIT (WD_LIMIT)
  ) u_wd (
    .clk   (clk),
    .rst   (rst),
    .clr_i (wd_clr),
    .en_i  (state_q != IDLE),
    .tc_o  (wd_tc)
  );

  // Next-state, HI/LO updates and stall decision.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d = state_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    a_d     = a_q;
    b_d     = b_q;
    sgn_d   = sgn_q;
    wr_d    = 1'b0;
    to_d    = to_q;
    wd_clr  = 1'b0;
    stall_o = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!flush) begin
          if (ex_div) begin
            if (is_div0) begin
              hi_d = ex_a;
              lo_d = DIV0_LO;
              wr_d = 1'b1;
            end else if (is_ovf) begin
              hi_d = '0;
              lo_d = SMIN;
              wr_d = 1'b1;
            end else begin
              a_d     = ex_a;
              b_d     = ex_b;
              sgn_d   = ex_signed;
              wd_clr  = 1'b1;
              stall_o = 1'b1;
              state_d = RUN;
            end
          end else if (ex_mthi || ex_mtlo) begin
            if (ex_mthi) hi_d = ex_wdata;
            if (ex_mtlo) lo_d = ex_wdata;
            wr_d = 1'b1;
          end
        end
      end

      RUN: begin
        if (div_ready) begin
          // A result arriving together with a flush belongs to a dead op.
          if (!flush) begin
            hi_d = div_result[63:32];
            lo_d = div_result[31:0];
            wr_d = 1'b1;
          end
          state_d = IDLE;
        end else begin
          stall_o = 1'b1;
          if (wd_tc) begin
            to_d    = 1'b1;
            state_d = IDLE;
          end else if (flush) begin
            state_d = DRAIN;
          end
        end
      end

      DRAIN: begin
        // Hold any new HI/LO user back until the stale division is gone.
        stall_o = ex_div || ex_mthi || ex_mtlo;
        if (div_ready) begin
          state_d = IDLE;
        end else if (wd_tc) begin
          to_d    = 1'b1;
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State, HI/LO, operand and flag registers.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst) begin
      state_q <= IDLE;
      hi_q    <= '0;
      lo_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sgn_q   <= 1'b0;
      wr_q    <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sgn_q   <= sgn_d;
      wr_q    <= wr_d;
      to_q    <= to_d;
    end
  end

  assign hi_o        = hi_q;
  assign lo_o        = lo_q;
  assign div_a       = a_q;
  assign div_b       = b_q;
  assign div_signed  = sgn_q;
  assign hilo_wr     = wr_q;
  assign div_timeout = to_q;

endmodule
